// File: rtl/inlet_dose_sequencer.sv
// inlet_dose_sequencer: round-robin sequencer driving one inlet valve plus the outlet valve per dose
module inlet_dose_sequencer #(
  parameter int N_INLETS      = 3,
  parameter int LEN_W         = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int DRAIN_CYCLES  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_INLETS-1:0]       req,
  input  logic [N_INLETS*LEN_W-1:0] req_len,
  input  logic                      abort,
  output logic [N_INLETS-1:0]       valve_in,
  output logic                      valve_out,
  output logic [N_INLETS-1:0]       grant,
  output logic [N_INLETS-1:0]       ack,
  output logic                      busy,
  output logic                      aborted
);
  localparam int IW = N_INLETS > 1 ? $clog2(N_INLETS) : 1;
  typedef enum logic [1:0] {IDLE, SETTLE, DOSE, DRAIN} state_t;
  state_t r_state, w_state;
  logic [IW-1:0] r_owner, w_owner, r_rr, w_rr, w_pick;
  logic [LEN_W-1:0] r_len, w_len, r_cnt, w_cnt;
  logic r_abt, w_abt, w_found;
  logic [N_INLETS-1:0] w_onehot, r_valve_in, r_grant, r_ack;
  logic r_valve_out, r_busy, r_aborted;
  // first requester at or after the rr pointer; reverse scan so the nearest one wins
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = N_INLETS - 1; i >= 0; i--) begin
      if (req[(int'(r_rr) + i) % N_INLETS]) begin
        w_found = 1'b1;
        w_pick  = IW'((int'(r_rr) + i) % N_INLETS);
      end
    end
  end
  // next-state logic; counters load with (duration-1) and run down to zero
  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_len   = r_len;
    w_cnt   = r_cnt;
    w_abt   = r_abt;
    w_rr    = r_rr;
    case (r_state)
      IDLE: if (w_found) begin
        w_state = SETTLE;
        w_owner = w_pick;
        w_len   = req_len[int'(w_pick)*LEN_W +: LEN_W];
        w_cnt   = LEN_W'(SETTLE_CYCLES - 1);
        w_abt   = 1'b0;
      end
      SETTLE: if (abort) begin
        w_state = DRAIN;
        w_cnt   = LEN_W'(DRAIN_CYCLES - 1);
        w_abt   = 1'b1;
      end else if (r_cnt == '0) begin
        w_state = (r_len == '0) ? DRAIN : DOSE;
        w_cnt   = (r_len == '0) ? LEN_W'(DRAIN_CYCLES - 1) : r_len - 1'b1;
      end else
        w_cnt = r_cnt - 1'b1;
      DOSE: if (abort || r_cnt == '0) begin
        w_state = DRAIN;
        w_cnt   = LEN_W'(DRAIN_CYCLES - 1);
        w_abt   = abort;
      end else
        w_cnt = r_cnt - 1'b1;
      default: if (r_cnt == '0) begin
        w_state = IDLE;
        w_rr    = (int'(r_owner) == N_INLETS - 1) ? '0 : r_owner + 1'b1;
      end else
        w_cnt = r_cnt - 1'b1;
    endcase
  end
  assign w_onehot = N_INLETS'(1) << w_owner;
  // state and glitch-free registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rr        <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_abt       <= 1'b0;
      r_valve_in  <= '0;
      r_valve_out <= 1'b0;
      r_grant     <= '0;
      r_ack       <= '0;
      r_busy      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_owner     <= w_owner;
      r_rr        <= w_rr;
      r_len       <= w_len;
      r_cnt       <= w_cnt;
      r_abt       <= w_abt;
      r_valve_in  <= (w_state == SETTLE || w_state == DOSE) ? w_onehot : '0;
      r_valve_out <= w_state == DOSE || w_state == DRAIN;
      r_grant     <= (w_state != IDLE) ? w_onehot : '0;
      r_ack       <= (w_state == DRAIN && w_cnt == '0) ? w_onehot : '0;
      r_busy      <= w_state != IDLE;
      r_aborted   <= w_state == DRAIN && w_cnt == '0 && w_abt;
    end
  end
  assign valve_in  = r_valve_in;
  assign valve_out = r_valve_out;
  assign grant     = r_grant;
  assign ack       = r_ack;
  assign busy      = r_busy;
  assign aborted   = r_aborted;
endmodule

// File: tb/tb_inlet_dose_sequencer.sv
// tb_inlet_dose_sequencer: directed scenarios for the inlet dose sequencer
module tb_inlet_dose_sequencer;
  logic clk = 0, rst_n = 0, abort = 0;
  logic [2:0] req = '0;
  logic [47:0] req_len = '0;
  logic [2:0] valve_in, grant, ack;
  logic valve_out, busy, aborted;
  int checks = 0, errors = 0;
  int m_settle = 0, m_dose = 0, m_drain = 0, m_ack = 0, m_abt = 0, m_bad = 0, cyc = 0;
  int s_settle, s_dose, s_drain, s_ack, s_abt;
  logic [2:0] last_ack = '0, prev_grant = '0;
  logic last_abt = 0;
  logic [2:0] grant_q[$];
  int gcyc_q[$], acyc_q[$];
  bit to;

  inlet_dose_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .abort(abort),
    .valve_in(valve_in), .valve_out(valve_out), .grant(grant), .ack(ack),
    .busy(busy), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // per-cycle monitor sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      cyc <= cyc + 1;
      if (valve_in != 0 && !valve_out) m_settle <= m_settle + 1;
      if (valve_in != 0 && valve_out) m_dose <= m_dose + 1;
      if (valve_in == 0 && valve_out) m_drain <= m_drain + 1;
      if (!$onehot0(valve_in) || !$onehot0(grant) || !$onehot0(ack)) m_bad <= m_bad + 1;
      if (aborted) m_abt <= m_abt + 1;
      if (ack != 0) begin
        m_ack <= m_ack + 1;
        last_ack <= ack;
        last_abt <= aborted;
        acyc_q.push_back(cyc);
      end
      if (grant != 0 && prev_grant == 0) begin
        grant_q.push_back(grant);
        gcyc_q.push_back(cyc);
      end
      prev_grant <= grant;
    end else
      prev_grant <= '0;
  end

  task automatic snap();
    s_settle = m_settle; s_dose = m_dose; s_drain = m_drain; s_ack = m_ack; s_abt = m_abt;
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic wait_acks(input int n, input int bound, output bit tmo);
    int start;
    start = m_ack;
    tmo = 1;
    repeat (bound) begin
      @(posedge clk); #1;
      if (m_ack >= start + n) begin tmo = 0; break; end
    end
  endtask

  task automatic wait_grant(input int bound, output bit tmo);
    tmo = 1;
    repeat (bound) begin
      @(posedge clk); #1;
      if (grant != 0) begin tmo = 0; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({valve_in, valve_out, grant, ack, busy, aborted} !== 12'b0) begin
      errors++; $display("FAIL reset_state: got %b want 0", {valve_in, valve_out, grant, ack, busy, aborted});
    end
    req_len[0 +: 16] = 16'd50;
    req = 3'b001;
    to = 1;
    repeat (30) begin
      @(posedge clk); #1;
      if (valve_out) begin to = 0; break; end
    end
    checks++;
    if (to || busy !== 1'b1) begin errors++; $display("FAIL reset_reach_dose: timeout=%0d busy=%b", to, busy); end
    snap();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({valve_in, valve_out, grant, busy, ack} !== 11'b0) begin
      errors++; $display("FAIL reset_async: got %b want 0", {valve_in, valve_out, grant, busy, ack});
    end
    req = 0;
    @(posedge clk); #1 rst_n = 1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (m_ack !== s_ack || busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_ack: acks=%0d want %0d busy=%b want 0", m_ack - s_ack, 0, busy);
    end
  endtask

  task automatic test_single();
    snap();
    req_len[0 +: 16] = 16'd5;
    req = 3'b001;
    wait_grant(5, to);
    checks++;
    if (to || grant !== 3'b001) begin errors++; $display("FAIL single_grant: got %b want 001", grant); end
    req = 0;
    wait_acks(1, 100, to);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (to || (m_settle - s_settle) + (m_dose - s_dose) != 13) begin
      errors++; $display("FAIL single_valve_in: got %0d cycles want 13", (m_settle - s_settle) + (m_dose - s_dose));
    end
    checks++;
    if ((m_dose - s_dose) + (m_drain - s_drain) != 21) begin
      errors++; $display("FAIL single_valve_out: got %0d cycles want 21", (m_dose - s_dose) + (m_drain - s_drain));
    end
    checks++;
    if (m_ack - s_ack != 1 || last_ack !== 3'b001 || last_abt !== 1'b0) begin
      errors++; $display("FAIL single_ack: count=%0d ack=%b abt=%b want 1/001/0", m_ack - s_ack, last_ack, last_abt);
    end
    checks++;
    if (busy !== 1'b0 || grant !== 3'b000) begin errors++; $display("FAIL single_idle: busy=%b grant=%b want 0/000", busy, grant); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    grant_q.delete(); gcyc_q.delete(); acyc_q.delete();
    snap();
    for (int i = 0; i < 3; i++) req_len[i*16 +: 16] = 16'd3;
    req = 3'b111;
    to = 1;
    repeat (200) begin
      @(posedge clk); #1;
      if (grant_q.size() >= 4) begin to = 0; break; end
    end
    req = 0;
    wait_acks(4 - (m_ack - s_ack), 200, to);
    checks++;
    if (to || grant_q.size() != 4 || acyc_q.size() != 4) begin
      errors++; $display("FAIL rr_progress: grants=%0d acks=%0d want 4/4", grant_q.size(), acyc_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_q[k] !== exp_g[k]) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", k, grant_q[k], exp_g[k]); end
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (gcyc_q[k+1] - acyc_q[k] != 2) begin
          errors++; $display("FAIL rr_turnaround[%0d]: got %0d want 2", k, gcyc_q[k+1] - acyc_q[k]);
        end
      end
    end
  endtask

  task automatic test_len_zero();
    snap();
    req_len[16 +: 16] = 16'd0;
    req = 3'b010;
    wait_grant(5, to);
    req = 0;
    checks++;
    if (to || grant !== 3'b010) begin errors++; $display("FAIL len0_grant: got %b want 010", grant); end
    wait_acks(1, 100, to);
    checks++;
    if (to || m_settle - s_settle != 8 || m_dose - s_dose != 0 || m_drain - s_drain != 16) begin
      errors++; $display("FAIL len0_phases: settle=%0d dose=%0d drain=%0d want 8/0/16", m_settle - s_settle, m_dose - s_dose, m_drain - s_drain);
    end
    checks++;
    if (last_ack !== 3'b010) begin errors++; $display("FAIL len0_ack: got %b want 010", last_ack); end
  endtask

  task automatic test_abort();
    snap();
    req_len[0 +: 16] = 16'd100;
    req = 3'b001;
    to = 1;
    repeat (30) begin
      @(posedge clk); #1;
      if (valve_out) begin to = 0; break; end
    end
    req = 0;
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    checks++;
    if (to || valve_in !== 3'b000 || valve_out !== 1'b1) begin
      errors++; $display("FAIL abort_drain_start: vin=%b vout=%b want 000/1", valve_in, valve_out);
    end
    wait_acks(1, 100, to);
    checks++;
    if (to || m_dose - s_dose != 2 || m_drain - s_drain != 16) begin
      errors++; $display("FAIL abort_phases: dose=%0d drain=%0d want 2/16", m_dose - s_dose, m_drain - s_drain);
    end
    checks++;
    if (last_ack !== 3'b001 || last_abt !== 1'b1 || m_abt - s_abt != 1) begin
      errors++; $display("FAIL abort_pulse: ack=%b aborted=%b count=%0d want 001/1/1", last_ack, last_abt, m_abt - s_abt);
    end
    snap();
    req_len[16 +: 16] = 16'd3;
    req = 3'b010;
    wait_grant(5, to);
    req = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valve_in == 0 && valve_out) break;
    end
    abort = 1;
    @(posedge clk); #1 abort = 0;
    wait_acks(1, 100, to);
    checks++;
    if (to || m_dose - s_dose != 3 || m_drain - s_drain != 16 || m_abt != s_abt || last_abt !== 1'b0) begin
      errors++; $display("FAIL abort_in_drain: dose=%0d drain=%0d aborted=%0d want 3/16/0", m_dose - s_dose, m_drain - s_drain, m_abt - s_abt);
    end
  endtask

  task automatic test_max_len();
    snap();
    req_len[32 +: 16] = 16'hFFFF;
    req = 3'b100;
    wait_grant(5, to);
    req = 0;
    checks++;
    if (to || grant !== 3'b100) begin errors++; $display("FAIL max_grant: got %b want 100", grant); end
    wait_acks(1, 70000, to);
    checks++;
    if (to || m_settle - s_settle != 8 || m_dose - s_dose != 65535 || m_drain - s_drain != 16) begin
      errors++; $display("FAIL max_len: settle=%0d dose=%0d drain=%0d want 8/65535/16", m_settle - s_settle, m_dose - s_dose, m_drain - s_drain);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_len_zero();
    test_abort();
    test_max_len();
    checks++;
    if (m_bad != 0) begin errors++; $display("FAIL onehot: %0d cycles with multiple valves/grants/acks, want 0", m_bad); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
